// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 codes, FSM states, request checks.
// Latency: none (package only).
// Backpressure: none (package only).
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // True when the request must be answered with an error and never touch the RAM:
    // an undefined funct3 for its direction, or a half/word access off its natural boundary.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = (f3 > F3_W);
        end else begin
            illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        misaligned = ((f3[1:0] == 2'd1) && addr_lo[0]) ||
                     ((f3[1:0] == 2'd2) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane merge for stores and lane select with sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are sampled.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Store merge: overwrite only the addressed lane, keep the rest of the RAM word.
    always_comb begin
        wword_o = word_i;
        case (func3_i[1:0])
            2'd0:    wword_o[{addr_lo_i, 3'b000} +: 8]      = wdata_i[7:0];
            2'd1:    wword_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: wword_o = wdata_i;
        endcase
    end

    // Load extract: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        rdata_o = word_i;
        case (func3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'd0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'd0, half_sel};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Sequential load/store controller between execute stage and a single-port synchronous data RAM.
// Latency (accept edge to response cycle, read latency 1): load 3, SB/SH 4, SW 2, error 1.
// Backpressure: one request at a time; oREQ_READY is low from the cycle after accept until the cycle after oRSP_VALID.
module data_mem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int RAM_RD_LATENCY = 1
)
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic        iREQ_WE,
    input  logic [2:0]  iFUNC3,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    output logic        oRSP_VALID,
    output logic        oRSP_ERR,
    output logic [31:0] oRDATA,
    output logic        oRAM_CE,
    output logic        oRAM_WR,
    output logic [31:0] oRAM_ADDR,
    output logic [31:0] oRAM_DATA,
    input  logic [31:0] iRAM_DATA
);

    localparam logic [1:0] LAST_WAIT = 2'(RAM_RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ce_q, ce_d;
    logic        wr_q, wr_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_data_q, ram_data_d;

    logic [31:0] merged;
    logic [31:0] extracted;

    // The RAM word is only meaningful on the last WAIT cycle; on that edge it is captured
    // straight into the write-data register (RMW) or the load-data register (load).
    mem_lane_align u_align (
        .addr_lo_i (alo_q),
        .func3_i   (f3_q),
        .word_i    (iRAM_DATA),
        .wdata_i   ({16'd0, wdata_q}),
        .wword_o   (merged),
        .rdata_o   (extracted)
    );

    // Next-state and next-output decode; every output is registered so it lines up with its state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        f3_d       = f3_q;
        alo_d      = alo_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = rsp_err_q;
        rdata_d    = rdata_q;
        ce_d       = 1'b0;
        wr_d       = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        case (state_q)
            ST_IDLE: begin
                if (iREQ_VALID && ready_q) begin
                    we_d    = iREQ_WE;
                    f3_d    = iFUNC3;
                    alo_d   = iADDR[1:0];
                    wdata_d = iWDATA[15:0];
                    if (req_bad(iREQ_WE, iFUNC3, iADDR[1:0])) begin
                        state_d   = ST_RESP;
                        rsp_vld_d = 1'b1;
                        rsp_err_d = 1'b1;
                        rdata_d   = 32'd0;
                    end else if (iREQ_WE && (iFUNC3 == F3_W)) begin
                        state_d    = ST_WRITE;
                        ce_d       = 1'b1;
                        wr_d       = 1'b1;
                        ram_addr_d = {iADDR[31:2], 2'b00};
                        ram_data_d = iWDATA;
                    end else begin
                        state_d    = ST_READ;
                        ce_d       = 1'b1;
                        ram_addr_d = {iADDR[31:2], 2'b00};
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                state_d    = ST_WAIT;
                wait_cnt_d = 2'd0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    if (we_q) begin
                        state_d    = ST_WRITE;
                        ce_d       = 1'b1;
                        wr_d       = 1'b1;
                        ram_data_d = merged;
                    end else begin
                        state_d   = ST_RESP;
                        rsp_vld_d = 1'b1;
                        rsp_err_d = 1'b0;
                        rdata_d   = extracted;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_WRITE: begin
                state_d   = ST_RESP;
                rsp_vld_d = 1'b1;
                rsp_err_d = 1'b0;
                rdata_d   = 32'd0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation, including a pending RMW write.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            alo_q      <= 2'd0;
            wdata_q    <= 16'd0;
            ready_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rdata_q    <= 32'd0;
            ce_q       <= 1'b0;
            wr_q       <= 1'b0;
            ram_addr_q <= 32'd0;
            ram_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            alo_q      <= alo_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rdata_q    <= rdata_d;
            ce_q       <= ce_d;
            wr_q       <= wr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign oREQ_READY = ready_q;
    assign oRSP_VALID = rsp_vld_q;
    assign oRSP_ERR   = rsp_err_q;
    assign oRDATA     = rdata_q;
    assign oRAM_CE    = ce_q;
    assign oRAM_WR    = wr_q;
    assign oRAM_ADDR  = ram_addr_q;
    assign oRAM_DATA  = ram_data_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequential data-memory controller for the RV32I core; sits between the execute stage (load/store decode) and the single-port synchronous data RAM.
- Accepts one load or store request at a time over a valid/ready handshake and issues RAM accesses.
- Byte/half stores use a two-phase read-modify-write (read word, merge lane, write word); word stores write directly.
- Loads are returned with sign/zero extension; misaligned or illegal requests get an error response and no RAM access.

Parameters:
- RAM_RD_LATENCY, 1, cycles from a RAM read cycle to valid iRAM_DATA; legal values are 1 or 2.

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  reset; asynchronous assert, active-low.
- iREQ_VALID  in  1  request present.
- oREQ_READY  out  1  controller idle; a request is accepted on a rising edge when iREQ_VALID and oREQ_READY are both high.
- iREQ_WE  in  1  1 = store, 0 = load.
- iFUNC3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- iADDR  in  32  byte address (rs1 + imm, computed upstream).
- iWDATA  in  32  store data (rs2).
- oRSP_VALID  out  1  one-cycle response pulse.
- oRSP_ERR  out  1  response flags a misaligned address or illegal funct3.
- oRDATA  out  32  extended load data; 0 for stores and errors.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_WR  out  1  RAM write strobe (valid only with CE).
- oRAM_ADDR  out  32  word address ({addr[31:2],2'b00}).
- oRAM_DATA  out  32  RAM write data.
- iRAM_DATA  in  32  RAM read data.

Behaviour:
- Reset: iRST_N low forces state IDLE asynchronously. oREQ_READY, oRSP_VALID, oRSP_ERR, oRAM_CE and oRAM_WR are 0; oRDATA, oRAM_ADDR and oRAM_DATA are 0. oREQ_READY rises on the first iCLK edge after release. All outputs are registered.
- On accept, the controller latches WE, FUNC3, ADDR and WDATA. oREQ_READY drops the next cycle and stays low until the cycle after oRSP_VALID.
- Errors: a load with funct3 3, 6 or 7, or a store with funct3 greater than 2, is illegal. A halfword access with addr[0]=1 or a word access with addr[1:0]≠0 is misaligned. Either case goes IDLE→RESP with oRSP_ERR=1 and no RAM activity.
- States are IDLE, READ, WAIT, WRITE, RESP.
  - READ: CE=1, WR=0, word address driven for 1 cycle.
  - WAIT: lasts RAM_RD_LATENCY cycles; iRAM_DATA is captured into a word register on the last WAIT edge.
  - WRITE: CE=1, WR=1 for 1 cycle.
  - RESP: oRSP_VALID=1 for 1 cycle, then IDLE.
- Transitions:
  - load: IDLE→READ→WAIT→RESP.
  - SB/SH: IDLE→READ→WAIT→WRITE→RESP.
  - SW: IDLE→WRITE→RESP.
- Latency from the accept edge to the oRSP_VALID cycle, with RAM_RD_LATENCY=1:
  - load: 3 cycles.
  - SB/SH: 4 cycles.
  - SW: 2 cycles.
  - error: 1 cycle.
  - Each extra cycle of RAM_RD_LATENCY adds 1 cycle to load and RMW latency.
- Store merge:
  - SB replaces byte lane addr[1:0] with WDATA[7:0] and keeps the other lanes from the captured word.
  - SH replaces the half at addr[1] with WDATA[15:0].
  - SW writes WDATA unchanged.
- Load extract:
  - LB/LBU select byte lane addr[1:0]; LH/LHU select half addr[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- oRDATA and oRSP_ERR are updated on entry to RESP and hold until the next response.
- oRAM_CE=0 in IDLE, WAIT and RESP. oRAM_ADDR and oRAM_DATA are don't-care when CE=0 and are held at their last value.
- iREQ_VALID while busy is ignored; the upstream stage must hold the request until accepted.
- Reset mid-operation: any state aborts to IDLE immediately; a pending RMW write is never issued and no response is produced.

Decomposition:
- Shared package rv_mem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - the state encoding;
  - a misaligned/illegal check function.
- Combinational sub-module mem_lane_align performs both the byte/half lane merge (store) and the lane select plus extension (load), given addr[1:0], funct3, word and wdata. The FSM stays in data_mem_ctrl.

Test Plan:
- RAM[0x100]=0x11223344; LB 0x103 → oRDATA=0x00000011, err=0, rsp 3 cycles after accept. LB 0x100 with RAM[0x100]=0x000000F0 → 0xFFFFFFF0; LBU → 0x000000F0.
- RAM[0x200]=0x80001234; LH 0x202 → 0xFFFF8000; LHU 0x202 → 0x00008000; LW 0x200 → 0x80001234.
- RAM[0x100]=0x11223344; SB 0x101 data 0x000000AB → one read of 0x100, then one write of 0x1122AB44 to 0x100; rsp 4 cycles after accept, oRDATA=0.
- SW 0x104 data 0xDEADBEEF → no read cycle, a single write of 0xDEADBEEF to 0x104, rsp 2 cycles after accept. SH 0x106 data 0xCAFE over 0xDEADBEEF → 0xCAFEBEEF.
- LW 0x102 and SH 0x103 → oRSP_ERR=1 one cycle after accept with oRAM_CE never asserted. Load funct3=3 → also err.
- Back-to-back SB then LW with iREQ_VALID held high: ready low during the SB, LW accepted the cycle after the SB response, LW returns the merged word. Separately, assert iRST_N low during WAIT of an SH → CE and WR stay 0, no write, no rsp, ready=1 one edge after release.
